nanocpu_dbus_io: RTL and testbench



---
 rtl/nanocpu_dbus_io_if.sv | 10 +
 rtl/nanocpu_dbus_io.sv | 77 +++++++
 tb/tb_nanocpu_dbus_io.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nanocpu_dbus_io_if.sv
// nanocpu_dbus_io_if: address, strobe and I/O pins between the nanoCPU data port and the bus slave.
interface nanocpu_dbus_io_if;
   logic [31:0] d_address;
   logic        mem_wr;
   logic [15:0] sw;
   logic [15:0] led;
   logic        timer_irq;
   modport master (output d_address, mem_wr, sw, input led, timer_irq);
   modport slave  (input d_address, mem_wr, sw, output led, timer_irq);
endinterface

// File: rtl/nanocpu_dbus_io.sv
// nanocpu_dbus_io: single-cycle data-bus slave with word RAM, LED/switch I/O and a prescaled compare timer.
module nanocpu_dbus_io #(
   parameter int          RAM_WORDS = 256,
   parameter int          PRESCALE  = 100,
   parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00
) (
   input  logic        clock,
   input  logic        reset,
   inout  wire  [31:0] d_data,
   nanocpu_dbus_io_if.slave bus
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   logic [31:0]   r_mem [RAM_WORDS];
   logic [15:0]   r_led, r_sw1, r_sw2;
   logic [31:0]   r_tcount, r_tcmp;
   logic          r_en, r_autoclr, r_match;
   logic [PW-1:0] r_pre;
   logic          w_ram_hit, w_io_hit, w_tick, w_hit_cmp, w_unused;
   logic          w_wr_led, w_wr_tcount, w_wr_tcmp, w_wr_tctrl;
   logic [5:0]    w_reg;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_io_rdata, w_rdata;
   assign w_ram_hit   = bus.d_address < 32'(RAM_WORDS * 4);
   assign w_io_hit    = bus.d_address[31:8] == IO_BASE[31:8];
   assign w_idx       = bus.d_address[AW+1:2];
   assign w_reg       = bus.d_address[7:2];
   assign w_wr_led    = bus.mem_wr && w_io_hit && w_reg == 6'd0;
   assign w_wr_tcount = bus.mem_wr && w_io_hit && w_reg == 6'd2;
   assign w_wr_tcmp   = bus.mem_wr && w_io_hit && w_reg == 6'd3;
   assign w_wr_tctrl  = bus.mem_wr && w_io_hit && w_reg == 6'd4;
   assign w_tick      = r_en && r_pre == PMAX;
   assign w_hit_cmp   = r_tcount == r_tcmp;
   assign w_unused    = ^bus.d_address[1:0];
   // RAM is never cleared; a write landing while reset is held is dropped
   always_ff @(posedge clock)
      if (!reset && bus.mem_wr && w_ram_hit) r_mem[w_idx] <= d_data;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_led     <= '0;
         r_sw1     <= '0;
         r_sw2     <= '0;
         r_tcount  <= '0;
         r_tcmp    <= '1;
         r_en      <= 1'b0;
         r_autoclr <= 1'b0;
         r_match   <= 1'b0;
         r_pre     <= '0;
      end else begin
         r_sw1 <= bus.sw;
         r_sw2 <= r_sw1;
         if (w_wr_led) r_led <= d_data[15:0];
         if (w_wr_tcmp) r_tcmp <= d_data;
         // a CPU write to TCOUNT swallows a coincident tick increment
         if (w_wr_tcount) r_tcount <= d_data;
         else if (w_tick) r_tcount <= (w_hit_cmp && r_autoclr) ? '0 : r_tcount + 32'd1;
         if (w_wr_tctrl) begin
            r_en      <= d_data[0];
            r_autoclr <= d_data[1];
         end
         if (w_tick && w_hit_cmp) r_match <= 1'b1;
         else if (w_wr_tctrl && d_data[2]) r_match <= 1'b0;
         r_pre <= (!r_en || w_tick || (w_wr_tctrl && !d_data[0])) ? '0 : r_pre + 1'b1;
      end
   always_comb begin
      w_io_rdata = (w_reg == 6'd0) ? {16'b0, r_led} :
                   (w_reg == 6'd1) ? {16'b0, r_sw2} :
                   (w_reg == 6'd2) ? r_tcount :
                   (w_reg == 6'd3) ? r_tcmp :
                   (w_reg == 6'd4) ? {29'b0, r_match, r_autoclr, r_en} : '0;
      w_rdata = w_ram_hit ? r_mem[w_idx] : w_io_hit ? w_io_rdata : '0;
   end
   assign d_data        = bus.mem_wr ? 'z : w_rdata;
   assign bus.led       = r_led;
   assign bus.timer_irq = r_match;
endmodule

// File: tb/tb_nanocpu_dbus_io.sv
// tb_nanocpu_dbus_io: directed scenarios for RAM, I/O registers, timer races and asynchronous reset.
module tb_nanocpu_dbus_io;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cpu_d = '0;
   logic [31:0] r;
   wire  [31:0] d_data;
   int          total = 0;
   int          bad = 0;
   nanocpu_dbus_io_if bus ();
   assign d_data = bus.mem_wr ? cpu_d : 32'bz;
   nanocpu_dbus_io #(.RAM_WORDS(256), .PRESCALE(4), .IO_BASE(32'hFFFF_FF00)) dut (
      .clock(clock), .reset(reset), .d_data(d_data), .bus(bus.slave));
   always #5 clock = ~clock;
   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      bus.d_address = a;
      cpu_d = v;
      bus.mem_wr = 1'b1;
      @(negedge clock);
      bus.mem_wr = 1'b0;
   endtask
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.d_address = a;
      bus.mem_wr = 1'b0;
      #1 d = d_data;
   endtask
   task automatic test_reset;
      bus.d_address = '0;
      bus.mem_wr = 1'b0;
      bus.sw = '0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      total++; if (bus.led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=0000", bus.led); end
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.timer_irq); end
      rd(32'hFFFF_FF0C, r);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_tcmp got=%h exp=ffffffff", r); end
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_tcount got=%h exp=00000000", r); end
      rd(32'hFFFF_FF10, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_tctrl got=%h exp=00000000", r); end
   endtask
   task automatic test_ram;
      wr(32'h0000_0010, 32'h1234_5678);
      rd(32'h0000_0010, r);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL ram_rd10 got=%h exp=12345678", r); end
      rd(32'h0000_0012, r);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL ram_rd12 got=%h exp=12345678", r); end
      wr(32'h0000_0014, 32'hDEAD_BEEF);
      rd(32'h0000_0010, r);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL ram_neighbour got=%h exp=12345678", r); end
      wr(32'h0000_03FC, 32'hA5A5_0F0F);
      rd(32'h0000_03FC, r);
      total++; if (r !== 32'hA5A5_0F0F) begin bad++; $display("FAIL ram_last got=%h exp=a5a50f0f", r); end
      rd(32'h0000_0400, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL ram_beyond got=%h exp=00000000", r); end
      rd(32'h8000_0000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=00000000", r); end
      bus.d_address = 32'h0000_0020;
      cpu_d = 32'hCAFE_F00D;
      bus.mem_wr = 1'b1;
      #1;
      total++; if (d_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL bus_release got=%h exp=cafef00d", d_data); end
      @(negedge clock);
      bus.mem_wr = 1'b0;
      rd(32'h0000_0020, r);
      total++; if (r !== 32'hCAFE_F00D) begin bad++; $display("FAIL ram_rd20 got=%h exp=cafef00d", r); end
   endtask
   task automatic test_io;
      wr(32'hFFFF_FF00, 32'h1234_ABCD);
      rd(32'hFFFF_FF00, r);
      total++; if (r !== 32'h0000_ABCD) begin bad++; $display("FAIL led_rd got=%h exp=0000abcd", r); end
      total++; if (bus.led !== 16'hABCD) begin bad++; $display("FAIL led_pin got=%h exp=abcd", bus.led); end
      rd(32'hFFFF_FF20, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL io_hole got=%h exp=00000000", r); end
      bus.sw = 16'h00A5;
      rd(32'hFFFF_FF04, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL sw_edge0 got=%h exp=00000000", r); end
      @(negedge clock);
      rd(32'hFFFF_FF04, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL sw_edge1 got=%h exp=00000000", r); end
      @(negedge clock);
      rd(32'hFFFF_FF04, r);
      total++; if (r !== 32'h0000_00A5) begin bad++; $display("FAIL sw_edge2 got=%h exp=000000a5", r); end
      wr(32'hFFFF_FF04, 32'hFFFF_FFFF);
      rd(32'hFFFF_FF04, r);
      total++; if (r !== 32'h0000_00A5) begin bad++; $display("FAIL sw_ro got=%h exp=000000a5", r); end
   endtask
   task automatic test_timer_match;
      logic [31:0] exp;
      wr(32'hFFFF_FF0C, 32'd3);
      wr(32'hFFFF_FF08, 32'd0);
      wr(32'hFFFF_FF10, 32'h3);
      for (int k = 1; k <= 4; k++) begin
         repeat (4) @(negedge clock);
         exp = (k == 4) ? 32'd0 : 32'(k);
         rd(32'hFFFF_FF08, r);
         total++; if (r !== exp) begin bad++; $display("FAIL tcount_step%0d got=%h exp=%h", k, r, exp); end
      end
      total++; if (bus.timer_irq !== 1'b1) begin bad++; $display("FAIL match_irq got=%b exp=1", bus.timer_irq); end
      rd(32'hFFFF_FF10, r);
      total++; if (r !== 32'h7) begin bad++; $display("FAIL match_tctrl got=%h exp=00000007", r); end
   endtask
   task automatic test_w1c_race;
      repeat (15) @(negedge clock);
      wr(32'hFFFF_FF10, 32'h7);
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL race_tcount got=%h exp=00000000", r); end
      rd(32'hFFFF_FF10, r);
      total++; if (r !== 32'h7) begin bad++; $display("FAIL race_set_wins got=%h exp=00000007", r); end
      wr(32'hFFFF_FF10, 32'h7);
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=0", bus.timer_irq); end
      rd(32'hFFFF_FF10, r);
      total++; if (r !== 32'h3) begin bad++; $display("FAIL w1c_tctrl got=%h exp=00000003", r); end
   endtask
   task automatic test_wrap;
      wr(32'hFFFF_FF10, 32'h0);
      wr(32'hFFFF_FF0C, 32'h0);
      wr(32'hFFFF_FF08, 32'hFFFF_FFFF);
      wr(32'hFFFF_FF10, 32'h1);
      repeat (4) @(negedge clock);
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL wrap_tcount got=%h exp=00000000", r); end
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL wrap_no_match got=%b exp=0", bus.timer_irq); end
      repeat (4) @(negedge clock);
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h1) begin bad++; $display("FAIL noclr_tcount got=%h exp=00000001", r); end
      rd(32'hFFFF_FF10, r);
      total++; if (r !== 32'h5) begin bad++; $display("FAIL noclr_tctrl got=%h exp=00000005", r); end
      repeat (3) @(negedge clock);
      wr(32'hFFFF_FF08, 32'h50);
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h50) begin bad++; $display("FAIL cpu_wins got=%h exp=00000050", r); end
      repeat (4) @(negedge clock);
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h51) begin bad++; $display("FAIL prescaler_kept got=%h exp=00000051", r); end
   endtask
   task automatic test_reset_mid;
      wr(32'hFFFF_FF00, 32'h0000_ABCD);
      wr(32'hFFFF_FF08, 32'd5);
      total++; if (bus.led !== 16'hABCD) begin bad++; $display("FAIL pre_reset_led got=%h exp=abcd", bus.led); end
      #2 reset = 1'b1;
      #1;
      total++; if (bus.led !== 16'h0) begin bad++; $display("FAIL async_led got=%h exp=0000", bus.led); end
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%b exp=0", bus.timer_irq); end
      rd(32'hFFFF_FF0C, r);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL async_tcmp got=%h exp=ffffffff", r); end
      rd(32'hFFFF_FF08, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL async_tcount got=%h exp=00000000", r); end
      rd(32'h0000_0010, r);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL ram_kept got=%h exp=12345678", r); end
      @(negedge clock);
      reset = 1'b0;
   endtask
   initial begin
      test_reset();
      test_ram();
      test_io();
      test_timer_match();
      test_w1c_race();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
